iot_dispatch: RTL and testbench
===============================

Name: iot_dispatch

Overview:
- Parametrised, sequential successor to the combinational IOT base decoder.
- Captures an IOT instruction, maps its 6-bit device code onto one of NUM_DEV device slots, and issues IOP1/IOP2/IOP4 pulses to the selected device in PDP-8 order.
- Waits for a per-device acknowledge after each pulse, collects the skip condition, and reports completion to the CPU sequencer.
- Sits between the instruction decode/timing logic and the peripheral devices.

Parameters:
NUM_DEV, 8, number of device slots (1..64)
DEV_BASE, 0, device code mapped to slot 0; slots cover DEV_BASE..DEV_BASE+NUM_DEV-1
TIMEOUT, 15, cycles to wait for ACK after each IOP pulse; 0 = wait forever
CNT_W, 8, timeout counter width; TIMEOUT must be < 2^CNT_W

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
IR  in  12  instruction register; IR[8:3] = device code, IR[2:0] = IOP bits (IR[0] = IOP1)
IOT  in  1  current instruction is an IOT (opcode 6)
CK_FETCH  in  1  fetch phase; start is suppressed while high
CK_3  in  1  execute strobe; start qualifier
DEV_ACK  in  NUM_DEV  per-slot acknowledge of the current IOP pulse
DEV_SKIP  in  NUM_DEV  per-slot skip request, sampled with DEV_ACK
DEV_SEL  out  NUM_DEV  one-hot select of the addressed slot
IOP  out  3  one-hot IOP pulse: 001 = IOP1, 010 = IOP2, 100 = IOP4
BUSY  out  1  transaction in progress
SKIP  out  1  skip result; valid while DONE = 1
DONE  out  1  one-cycle transaction-complete pulse
UNMAPPED  out  1  qualifies DONE: device code outside the slot range
TIMEOUT_ERR  out  1  qualifies DONE: an ACK wait expired

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the counter and accumulators are cleared. A reset during any state aborts the transaction on the next edge, with no DONE pulse.
- Start condition: IOT & CK_3 & ~CK_FETCH, sampled only in IDLE. Starts in any other state are ignored.
- IDLE:
  - On start, latch dev = IR[8:3] and op = IR[2:0], set BUSY, clear the skip accumulator.
  - If dev is outside the slot range, go to FINISH with UNMAPPED set.
  - Else if op = 0, go to FINISH with no pulses.
  - Else go to PULSE with bit = lowest set bit of op.
- PULSE (one cycle):
  - DEV_SEL[dev-DEV_BASE] = 1 and IOP = 1<<bit.
  - Load the counter with TIMEOUT, then go to WAIT.
- WAIT:
  - DEV_SEL stays asserted and IOP = 000.
  - On DEV_ACK[slot], OR DEV_SKIP[slot] into the skip accumulator. Then go to PULSE for the next higher set bit of op, or to FINISH if none remain.
  - ACK/SKIP from unselected slots are ignored.
  - With TIMEOUT ≠ 0, the counter decrements each WAIT cycle without ACK. On reaching 0, set TIMEOUT_ERR, abandon the remaining bits, and go to FINISH.
- ACK during PULSE: an ACK asserted in the PULSE cycle is honoured as if it arrived in the first WAIT cycle, with the transition out of PULSE taken directly.
- FINISH (one cycle):
  - DONE = 1; SKIP = accumulator (forced to 0 on UNMAPPED or TIMEOUT_ERR); UNMAPPED and TIMEOUT_ERR are valid; DEV_SEL = 0.
  - Next state is IDLE and BUSY = 0.
- DONE is a one-cycle pulse; UNMAPPED and TIMEOUT_ERR are high only during FINISH.
- Latency, with start sampled at edge N:
  - Unmapped or op = 0: DONE high in cycle N+1.
  - Mapped: first IOP pulse in cycle N+1. Each bit takes 1 cycle with ACK in PULSE, else 1 + k cycles with ACK k cycles later. DONE follows the last ACK by one cycle.
- Slot arithmetic is unsigned 6-bit. The range check must not wrap when DEV_BASE+NUM_DEV > 64; codes ≥ 64 simply do not exist.
- DEV_SEL and IOP are registered outputs, glitch-free.

Test Plan:
- IR=12'o6031, DEV_BASE=0, slot 3 ACKs in PULSE with SKIP=1 -> DEV_SEL=8'h08 and IOP=001 in cycle N+1; DONE=1, SKIP=1 in N+2.
- IR=12'o6047, slot 4 ACKs 2 cycles after each pulse, DEV_SKIP=1 only at the IOP2 ACK -> IOP sequence 001, 010, 100 in order; DONE with SKIP=1, total 10 cycles from start to DONE.
- IR=12'o6371 (dev 37) with NUM_DEV=8 -> UNMAPPED=1, DONE=1, SKIP=0 in cycle N+1; DEV_SEL stays 0 throughout.
- IR=12'o6012, slot 1 never ACKs, TIMEOUT=15 -> IOP=010 pulse, then DONE with TIMEOUT_ERR=1 and SKIP=0 after 15 WAIT cycles.
- Start reissued while BUSY, and ACK/SKIP driven on unselected slots -> no effect on state or SKIP.
- RESET asserted mid-WAIT -> next cycle all outputs 0, no DONE; a fresh start then behaves normally.
- CK_FETCH=1 with IOT=1 and CK_3=1 -> no start, BUSY stays 0.

Source files
------------

// File: rtl/iot_dispatch.sv
// IOT dispatcher: latches an IOT, pulses IOP1/2/4 at one device slot in order, waits for
// each acknowledge (with optional timeout) and reports skip/completion to the sequencer.
module iot_dispatch #(
   parameter int unsigned NUM_DEV  = 8,
   parameter int unsigned DEV_BASE = 0,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [11:0]        IR,
   input  logic               IOT,
   input  logic               CK_FETCH,
   input  logic               CK_3,
   input  logic [NUM_DEV-1:0] DEV_ACK,
   input  logic [NUM_DEV-1:0] DEV_SKIP,
   output logic [NUM_DEV-1:0] DEV_SEL,
   output logic [2:0]         IOP,
   output logic               BUSY,
   output logic               SKIP,
   output logic               DONE,
   output logic               UNMAPPED,
   output logic               TIMEOUT_ERR
);

   typedef enum logic [1:0] {StIdle, StPulse, StWait, StFinish} state_e;

   localparam logic [6:0]       BaseW   = 7'(DEV_BASE);
   localparam logic [6:0]       NumW    = 7'(NUM_DEV);
   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(TIMEOUT);

   function automatic logic [2:0] low_bit(input logic [2:0] v);
      return v & (~v + 3'd1);
   endfunction

   state_e             state_q;
   logic [NUM_DEV-1:0] dev_sel_q;
   logic [2:0]         iop_q;
   logic [2:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               acc_q;
   logic               busy_q;
   logic               skip_q;
   logic               done_q;
   logic               unmapped_q;
   logic               tmo_q;

   logic               start;
   logic [6:0]         dev_w;
   logic [6:0]         slot_w;
   logic               mapped;
   logic [NUM_DEV-1:0] sel_onehot;
   logic [2:0]         ir_low;
   logic [2:0]         op_low;
   logic               ack_hit;
   logic               skip_hit;
   logic               unused_ir;

   assign start      = IOT & CK_3 & ~CK_FETCH;
   // 7-bit arithmetic so DEV_BASE+NUM_DEV beyond 64 cannot wrap back onto low codes
   assign dev_w      = {1'b0, IR[8:3]};
   assign slot_w     = dev_w - BaseW;
   assign mapped     = (dev_w >= BaseW) && (slot_w < NumW);
   assign sel_onehot = NUM_DEV'(1) << slot_w[5:0];
   assign ir_low     = low_bit(IR[2:0]);
   assign op_low     = low_bit(op_q);
   assign ack_hit    = |(DEV_ACK & dev_sel_q);
   assign skip_hit   = |(DEV_SKIP & dev_sel_q);
   assign unused_ir  = ^IR[11:9];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= StIdle;
         dev_sel_q  <= '0;
         iop_q      <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         acc_q      <= 1'b0;
         busy_q     <= 1'b0;
         skip_q     <= 1'b0;
         done_q     <= 1'b0;
         unmapped_q <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         iop_q      <= '0;
         skip_q     <= 1'b0;
         done_q     <= 1'b0;
         unmapped_q <= 1'b0;
         tmo_q      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy_q <= 1'b1;
                  acc_q  <= 1'b0;
                  if (!mapped) begin
                     state_q    <= StFinish;
                     done_q     <= 1'b1;
                     unmapped_q <= 1'b1;
                  end else if (IR[2:0] == 3'b000) begin
                     state_q <= StFinish;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= StPulse;
                     dev_sel_q <= sel_onehot;
                     iop_q     <= ir_low;
                     op_q      <= IR[2:0] & ~ir_low;
                  end
               end
            end
            StPulse, StWait: begin
               // an ACK already present in the pulse cycle is taken without entering WAIT
               if (ack_hit) begin
                  acc_q <= acc_q | skip_hit;
                  if (op_q != 3'b000) begin
                     state_q <= StPulse;
                     iop_q   <= op_low;
                     op_q    <= op_q & ~op_low;
                  end else begin
                     state_q   <= StFinish;
                     done_q    <= 1'b1;
                     skip_q    <= acc_q | skip_hit;
                     dev_sel_q <= '0;
                  end
               end else if (state_q == StPulse) begin
                  state_q <= StWait;
                  cnt_q   <= CntLoad;
               end else if (TIMEOUT != 0) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q   <= StFinish;
                     done_q    <= 1'b1;
                     tmo_q     <= 1'b1;
                     dev_sel_q <= '0;
                     op_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            StFinish: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign DEV_SEL     = dev_sel_q;
   assign IOP         = iop_q;
   assign BUSY        = busy_q;
   assign SKIP        = skip_q;
   assign DONE        = done_q;
   assign UNMAPPED    = unmapped_q;
   assign TIMEOUT_ERR = tmo_q;

endmodule

// File: tb/tb_iot_dispatch.sv
// Scoreboard bench for iot_dispatch: a device responder acks IOP pulses after programmed
// delays while unselected slots carry random ACK/SKIP noise.
module tb_iot_dispatch;

   localparam int NumDev  = 8;
   localparam int DevBase = 0;
   localparam int Tmo     = 15;

   typedef struct {
      logic [7:0] sel;
      logic [8:0] seq;
      logic       skip;
      logic       unm;
      logic       tmo;
      int         lat;
      int         start_cyc;
   } exp_t;

   logic              CLK = 1'b0;
   logic              RESET = 1'b1;
   logic [11:0]       IR = '0;
   logic              IOT = 1'b0;
   logic              CK_FETCH = 1'b0;
   logic              CK_3 = 1'b0;
   logic [NumDev-1:0] DEV_ACK = '0;
   logic [NumDev-1:0] DEV_SKIP = '0;
   logic [NumDev-1:0] DEV_SEL;
   logic [2:0]        IOP;
   logic              BUSY, SKIP, DONE, UNMAPPED, TIMEOUT_ERR;

   iot_dispatch #(
      .NUM_DEV (NumDev),
      .DEV_BASE(DevBase),
      .TIMEOUT (Tmo),
      .CNT_W   (8)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .IR         (IR),
      .IOT        (IOT),
      .CK_FETCH   (CK_FETCH),
      .CK_3       (CK_3),
      .DEV_ACK    (DEV_ACK),
      .DEV_SKIP   (DEV_SKIP),
      .DEV_SEL    (DEV_SEL),
      .IOP        (IOP),
      .BUSY       (BUSY),
      .SKIP       (SKIP),
      .DONE       (DONE),
      .UNMAPPED   (UNMAPPED),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   bit         mon_en = 1'b0;
   logic [8:0] mon_seq = '0;
   logic [7:0] mon_sel = '0;

   int         cfg_slot = 0;
   int         cfg_delay[3] = '{0, 0, 0};
   logic [2:0] cfg_skip = '0;
   int         dev_cnt = 0;
   logic       dev_pend_skip = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Device responder: acks the selected slot k cycles after each pulse; SKIP on that slot is
   // random except in the ACK cycle, and every other slot is random noise.
   always @(negedge CLK) begin
      logic       ack_v;
      logic [7:0] mask;
      int         b;
      int         k;
      ack_v = 1'b0;
      if (IOP != 3'b000) begin
         b = IOP[0] ? 0 : (IOP[1] ? 1 : 2);
         k = cfg_delay[b];
         dev_pend_skip = cfg_skip[b];
         dev_cnt = 0;
         if (k == 0) ack_v = 1'b1;
         else if (k > 0) dev_cnt = k;
      end else if (dev_cnt > 0) begin
         dev_cnt--;
         if (dev_cnt == 0) ack_v = 1'b1;
      end
      mask = 8'(1) << cfg_slot;
      DEV_ACK  = (8'($urandom) & ~mask) | (ack_v ? mask : 8'h00);
      DEV_SKIP = (8'($urandom) & ~mask) |
                 ((ack_v ? dev_pend_skip : 1'($urandom)) ? mask : 8'h00);
   end

   always @(negedge CLK) begin
      exp_t e;
      if (mon_en) begin
         if (IOP != 3'b000) mon_seq = {mon_seq[5:0], IOP};
         mon_sel = mon_sel | DEV_SEL;
         if (!DONE) chk("flags_outside_done", {30'd0, UNMAPPED, TIMEOUT_ERR}, 32'd0);
         if (DONE) begin
            if (sb.size() == 0) begin
               chk("spurious_done", {31'd0, DONE}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("skip", {31'd0, SKIP}, {31'd0, e.skip});
               chk("unmapped", {31'd0, UNMAPPED}, {31'd0, e.unm});
               chk("timeout_err", {31'd0, TIMEOUT_ERR}, {31'd0, e.tmo});
               chk("latency", cyc - e.start_cyc, e.lat);
               chk("iop_seq", {23'd0, mon_seq}, {23'd0, e.seq});
               chk("dev_sel_seen", {24'd0, mon_sel}, {24'd0, e.sel});
               chk("dev_sel_at_done", {24'd0, DEV_SEL}, 32'd0);
            end
            mon_seq = '0;
            mon_sel = '0;
         end
      end
   end

   // Build the expected result from the instruction and the responder program, then start.
   task automatic issue(input logic [11:0] ir, input int d0, input int d1, input int d2,
                        input logic [2:0] sk);
      exp_t e;
      int   dev, slot, dl[3];
      logic [2:0] op;
      logic acc;
      bit   mapped;
      dl     = '{d0, d1, d2};
      dev    = int'(ir[8:3]);
      op     = ir[2:0];
      mapped = (dev >= DevBase) && (dev < DevBase + NumDev);
      slot   = mapped ? dev - DevBase : 0;
      acc    = 1'b0;
      e.sel  = '0;
      e.seq  = '0;
      e.skip = 1'b0;
      e.unm  = !mapped;
      e.tmo  = 1'b0;
      e.lat  = 1;
      if (mapped && op != 3'b000) begin
         e.sel = 8'(1) << slot;
         for (int b = 0; b < 3; b++) begin
            if (op[b]) begin
               e.seq = {e.seq[5:0], 3'(1 << b)};
               if (dl[b] < 0 || dl[b] > Tmo) begin
                  e.lat += 1 + Tmo;
                  e.tmo = 1'b1;
                  break;
               end
               e.lat += 1 + dl[b];
               acc |= sk[b];
            end
         end
         e.skip = e.tmo ? 1'b0 : acc;
      end
      cfg_slot  = slot;
      cfg_delay = dl;
      cfg_skip  = sk;
      e.start_cyc = cyc;
      sb.push_back(e);
      IR  = ir;
      IOT = 1'b1;
      CK_3 = 1'b1;
      @(negedge CLK);
      IOT  = 1'b0;
      CK_3 = 1'b0;
      IR   = 12'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
      if (sb.size() != 0) begin
         chk("done_within_budget", sb.size(), 0);
         sb.delete();
      end
      @(negedge CLK);
      chk("busy_after_done", {31'd0, BUSY}, 32'd0);
   endtask

   task automatic run(input logic [11:0] ir, input int d0, input int d1, input int d2,
                      input logic [2:0] sk);
      issue(ir, d0, d1, d2, sk);
      drain();
   endtask

   initial begin
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      chk("reset_outputs", {20'd0, DEV_SEL, IOP, BUSY, SKIP, DONE, UNMAPPED, TIMEOUT_ERR},
          32'd0);
      RESET  = 1'b0;
      mon_en = 1'b1;
      @(negedge CLK);

      run(12'o6031, 0, 0, 0, 3'b001);    // slot 3, ACK in PULSE with skip
      // slot 4, all three pulses acked 2 cycles late; a start mid-transaction must be ignored
      issue(12'o6047, 2, 2, 2, 3'b010);
      repeat (2) @(negedge CLK);
      IR = 12'o6051; IOT = 1'b1; CK_3 = 1'b1;
      @(negedge CLK);
      chk("busy_during_reissue", {31'd0, BUSY}, 32'd1);
      IOT = 1'b0; CK_3 = 1'b0;
      drain();
      run(12'o6371, 0, 0, 0, 3'b111);    // dev 37 unmapped
      run(12'o6012, 0, -1, 0, 3'b010);   // slot 1 never acks
      run(12'o6040, 0, 0, 0, 3'b111);    // op = 0
      run(12'o6075, 1, 0, 0, 3'b000);    // slot 7, IOP1 + IOP4
      run(12'o6103, 0, 0, 0, 3'b011);    // dev 8, first code past the range
      run(12'o6003, 15, 3, 0, 3'b010);   // ACK on the last allowed WAIT cycle
      run(12'o6001, 16, 0, 0, 3'b001);   // ACK one cycle too late
      run(12'o6026, 0, 5, 1, 3'b110);    // slot 2, IOP2 + IOP4

      // reset in the middle of a WAIT
      issue(12'o6012, 0, -1, 0, 3'b000);
      repeat (5) @(negedge CLK);
      chk("in_wait_busy", {31'd0, BUSY}, 32'd1);
      RESET = 1'b1;
      @(negedge CLK);
      chk("reset_mid_wait", {20'd0, DEV_SEL, IOP, BUSY, SKIP, DONE, UNMAPPED, TIMEOUT_ERR},
          32'd0);
      RESET = 1'b0;
      sb.delete();
      mon_seq = '0;
      mon_sel = '0;
      repeat (20) @(negedge CLK);
      run(12'o6031, 0, 0, 0, 3'b001);

      // fetch phase suppresses the start
      IR = 12'o6031; IOT = 1'b1; CK_3 = 1'b1; CK_FETCH = 1'b1;
      @(negedge CLK);
      chk("fetch_no_start", {31'd0, BUSY}, 32'd0);
      IOT = 1'b0; CK_3 = 1'b0; CK_FETCH = 1'b0;
      repeat (3) @(negedge CLK);
      chk("fetch_still_idle", {24'd0, DEV_SEL}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=hang exp=finish");
      $fatal(1);
   end

endmodule
